// File: rtl/ex_wb_skid.sv
// Execute-to-writeback pipeline register built as a two-entry skid buffer.
// ex_ready is registered-state only, so writeback stalls never reach execute combinationally.
module ex_wb_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [2:0]        ex_dest,
  input  logic [1:0]        ex_size,
  input  logic [5:0]        ex_flags,
  input  logic              ex_flags_we,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic [2:0]        wb_dest,
  output logic [1:0]        wb_size,
  output logic [5:0]        wb_flags,
  output logic              wb_flags_we,
  output logic [1:0]        count
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid and the head fields hold steady until that transfer completes.
  localparam int ENT_W = DATA_W + 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ENT_W-1:0]  r_head;
  logic [ENT_W-1:0]  r_skid;
  logic [ENT_W-1:0]  w_in;
  logic [DATA_W-1:0] w_masked;
  logic              w_push;
  logic              w_pop;
  logic              w_head_ld_in;
  logic              w_head_ld_skid;
  logic              w_skid_ld;

  always_comb begin
    case (ex_size)
      2'b00:   w_masked = ex_result & {{(DATA_W-8){1'b0}}, 8'hFF};
      2'b01:   w_masked = ex_result & {{(DATA_W-16){1'b0}}, 16'hFFFF};
      default: w_masked = ex_result;
    endcase
  end

  assign w_in     = {w_masked, ex_dest, ex_size, ex_flags, ex_flags_we};
  assign wb_valid = (r_state != EMPTY);
  assign ex_ready = ~rst & (r_state != FULL);
  assign w_push   = ex_valid & ex_ready;
  assign w_pop    = wb_valid & wb_ready;

  always_comb begin
    w_next         = r_state;
    w_head_ld_in   = 1'b0;
    w_head_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      // Any same-cycle pop still completes; the push is simply not captured.
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_next       = ONE;
            w_head_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_head_ld_in = 1'b1;
          end else if (w_push) begin
            w_next    = FULL;
            w_skid_ld = 1'b1;
          end else if (w_pop) begin
            w_next = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_next         = ONE;
            w_head_ld_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      if (w_head_ld_in) begin
        r_head <= w_in;
      end else if (w_head_ld_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= w_in;
      end
    end
  end

  assign wb_result   = r_head[ENT_W-1:12];
  assign wb_dest     = r_head[11:9];
  assign wb_size     = r_head[8:7];
  assign wb_flags    = r_head[6:1];
  assign wb_flags_we = r_head[0];
  assign count       = r_state;

endmodule

// File: tb/tb_ex_wb_skid.sv
// Bench for ex_wb_skid: directed scenarios then random traffic, scored against an
// in-order queue model of the buffer contents.
module tb_ex_wb_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [2:0]  ex_dest;
  logic [1:0]  ex_size;
  logic [5:0]  ex_flags;
  logic        ex_flags_we;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [2:0]  wb_dest;
  logic [1:0]  wb_size;
  logic [5:0]  wb_flags;
  logic        wb_flags_we;
  logic [1:0]  count;

  ex_wb_skid #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_dest(ex_dest), .ex_size(ex_size), .ex_flags(ex_flags), .ex_flags_we(ex_flags_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_dest(wb_dest), .wb_size(wb_size), .wb_flags(wb_flags), .wb_flags_we(wb_flags_we),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [43:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          p_size = 0;
  bit          started = 0;
  bit          reset_clean = 0;

  function automatic logic [31:0] model_mask(input logic [31:0] r, input logic [1:0] s);
    if (s == 2'd0)      return r % 32'h100;
    else if (s == 2'd1) return r % 32'h1_0000;
    else                return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1ns after each rising edge; first the effect of the previous
  // cycle's inputs is folded into the model.
  task automatic step(input logic t_rst, input logic t_flush, input logic t_v,
                      input logic [31:0] t_res, input logic [2:0] t_dest,
                      input logic [1:0] t_size, input logic [5:0] t_flags,
                      input logic t_we, input logic t_wbr);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      reset_clean = 1;
    end else if (flush) begin
      exp_q.delete();
    end else if (ex_valid && p_size < 2) begin
      exp_q.push_back({model_mask(ex_result, ex_size), ex_dest, ex_size, ex_flags, ex_flags_we});
      reset_clean = 0;
    end
    started     = 1;
    p_size      = exp_q.size();
    rst         = t_rst;
    flush       = t_flush;
    ex_valid    = t_v;
    ex_result   = t_res;
    ex_dest     = t_dest;
    ex_size     = t_size;
    ex_flags    = t_flags;
    ex_flags_we = t_we;
    wb_ready    = t_wbr;
  endtask

  task automatic idle(input logic t_wbr);
    step(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 6'd0, 1'b0, t_wbr);
  endtask

  task automatic push(input logic [31:0] r, input logic [2:0] d, input logic [1:0] s,
                      input logic t_wbr);
    step(1'b0, 1'b0, 1'b1, r, d, s, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), t_wbr);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int sz;
    logic [43:0] e;
    if (started) begin
      sz = exp_q.size();
      chk("count", 64'(count), 64'(sz));
      chk("wb_valid", 64'(wb_valid), 64'(sz != 0));
      chk("ex_ready", 64'(ex_ready), 64'(!rst && sz < 2));
      if (sz > 0) begin
        e = exp_q[0];
        chk("wb_result", 64'(wb_result), 64'(e[43:12]));
        chk("wb_dest", 64'(wb_dest), 64'(e[11:9]));
        chk("wb_size", 64'(wb_size), 64'(e[8:7]));
        chk("wb_flags", 64'(wb_flags), 64'(e[6:1]));
        chk("wb_flags_we", 64'(wb_flags_we), 64'(e[0]));
        if (wb_ready) void'(exp_q.pop_front());
      end else if (reset_clean) begin
        chk("rst_wb_fields", {20'd0, wb_result, wb_dest, wb_size, wb_flags, wb_flags_we}, 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_dest = '0;
    ex_size = '0; ex_flags = '0; ex_flags_we = 1'b0; wb_ready = 1'b0;
    step(1'b1, 1'b0, 1'b1, 32'h5, 3'd1, 2'd2, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // streaming at full rate
    push(32'h1111_1111, 3'd1, 2'd2, 1'b1);
    push(32'h2222_2222, 3'd2, 2'd2, 1'b1);
    push(32'h3333_3333, 3'd3, 2'd2, 1'b1);
    idle(1'b1);

    // size masking
    push(32'hDEAD_BEEF, 3'd4, 2'd0, 1'b1);
    push(32'hDEAD_BEEF, 3'd5, 2'd1, 1'b1);
    push(32'hDEAD_BEEF, 3'd6, 2'd2, 1'b1);
    push(32'hDEAD_BEEF, 3'd7, 2'd3, 1'b1);
    idle(1'b1);

    // backpressure: A then B absorbed, C refused while full
    push(32'hAAAA_0001, 3'd3, 2'd2, 1'b0);
    push(32'hBBBB_0002, 3'd5, 2'd2, 1'b0);
    push(32'hCCCC_0003, 3'd6, 2'd2, 1'b0);
    push(32'hCCCC_0003, 3'd6, 2'd2, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush while full, with a same-cycle push
    push(32'h0101_0101, 3'd1, 2'd2, 1'b0);
    push(32'h0202_0202, 3'd2, 2'd2, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hF00D_F00D, 3'd7, 2'd2, 6'h3F, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // reset mid-stream with a push pending
    push(32'h1234_5678, 3'd2, 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8765_4321, 3'd4, 2'd2, 6'h15, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // simultaneous push and pop in ONE
    push(32'hAB00_00CD, 3'd1, 2'd2, 1'b0);
    push(32'h00EF_0000, 3'd2, 2'd1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
